// File: rtl/motion_cmd_sequencer_if.sv
// Command/acknowledge bundle between the motion command sequencer and its consumer.
//   start, abort, product_complete : requests into the sequencer
//   motion_cmd                     : 3-bit command (000 MOVE_PICK .. 011 PLACE, 111 NOP)
//   busy, done, error              : sequencer status
//   product_count                  : products acknowledged in the current batch
// Modports: master = sequencer side, slave = consumer / stimulus side.
interface motion_cmd_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             product_complete;
    logic [2:0]       motion_cmd;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] product_count;

    modport master (
        input  start, abort, product_complete,
        output motion_cmd, busy, done, error, product_count
    );

    modport slave (
        output start, abort, product_complete,
        input  motion_cmd, busy, done, error, product_count
    );
endinterface

// File: rtl/motion_cmd_sequencer.sv
// Issues the per-product command cycle MOVE_PICK -> PICK -> MOVE_PLACE -> PLACE, holding each
// command for HOLD_CYCLES clocks, then waits for product_complete. Repeats until BATCH_SIZE
// products are accepted (DONE) or the acknowledge stops arriving (ERROR after TIMEOUT_CYCLES).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : motion_cmd_sequencer_if master modport (requests in, command/status out)
// All outputs are registered and derived from the next state.
module motion_cmd_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned BATCH_SIZE     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    motion_cmd_sequencer_if.master  bus
);

    // Command states share their encoding with motion_cmd, so bit 2 clear means "command".
    localparam logic [2:0] StMovePick  = 3'd0;
    localparam logic [2:0] StPick      = 3'd1;
    localparam logic [2:0] StMovePlace = 3'd2;
    localparam logic [2:0] StPlace     = 3'd3;
    localparam logic [2:0] StIdle      = 3'd4;
    localparam logic [2:0] StWaitAck   = 3'd5;
    localparam logic [2:0] StDone      = 3'd6;
    localparam logic [2:0] StError     = 3'd7;

    localparam logic [2:0] CmdNop = 3'b111;

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLast    = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BatchSize = CNT_W'(BATCH_SIZE);

    logic [2:0]       state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ack_seen_q, ack_seen_d;
    logic [2:0]       motion_cmd_q, motion_cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic accept;
    logic state_busy;

    assign state_busy = ~state_q[2] | (state_q == StWaitAck);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        count_d    = count_q;
        ack_seen_d = ack_seen_q;
        accept     = 1'b0;

        case (state_q)
            StIdle, StDone, StError: begin
                if (bus.start) begin
                    state_d    = StMovePick;
                    hold_cnt_d = '0;
                    count_d    = '0;
                end
            end
            StMovePick, StPick, StMovePlace: begin
                if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d = '0;
                    state_d    = state_q + 3'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StPlace: begin
                if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d = '0;
                    if (ack_seen_q || bus.product_complete) begin
                        accept = 1'b1;
                    end else begin
                        state_d  = StWaitAck;
                        to_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StWaitAck: begin
                if (bus.product_complete) begin
                    accept = 1'b1;
                end else if (to_cnt_q == ToLast) begin
                    state_d = StError;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // One increment per product regardless of how long the ack is held.
        if (accept) begin
            count_d = count_q + 1'b1;
            state_d = (count_d == BatchSize) ? StDone : StMovePick;
        end

        // Abort overrides everything in busy states, including an acceptance this clock.
        if (state_busy && bus.abort) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
            to_cnt_d   = '0;
            count_d    = count_q;
        end

        if ((state_q == StPlace || state_q == StWaitAck) && bus.product_complete) begin
            ack_seen_d = 1'b1;
        end
        if (state_d == StMovePick && state_q != StMovePick) begin
            ack_seen_d = 1'b0;
        end

        motion_cmd_d = state_d[2] ? CmdNop : state_d;
        busy_d       = ~state_d[2] | (state_d == StWaitAck);
        done_d       = (state_d == StDone);
        error_d      = (state_d == StError);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            to_cnt_q     <= '0;
            count_q      <= '0;
            ack_seen_q   <= 1'b0;
            motion_cmd_q <= CmdNop;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            to_cnt_q     <= to_cnt_d;
            count_q      <= count_d;
            ack_seen_q   <= ack_seen_d;
            motion_cmd_q <= motion_cmd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.motion_cmd    = motion_cmd_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.product_count = count_q;

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
module tb_motion_cmd_sequencer;

    localparam int unsigned CntW = 8;

    logic clock;
    logic reset;

    int checks;
    int errors;

    motion_cmd_sequencer_if #(.CNT_W(CntW)) bus ();

    motion_cmd_sequencer #(
        .HOLD_CYCLES   (2),
        .BATCH_SIZE    (3),
        .TIMEOUT_CYCLES(8),
        .CNT_W         (CntW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected command per clock of one product cycle.
    logic [2:0] cmd_seq [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmd_seq[0] = 3'b000; cmd_seq[1] = 3'b000;
        cmd_seq[2] = 3'b001; cmd_seq[3] = 3'b001;
        cmd_seq[4] = 3'b010; cmd_seq[5] = 3'b010;
        cmd_seq[6] = 3'b011; cmd_seq[7] = 3'b011;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.product_complete = 1'b0;

        // 1. reset
        reset = 1'b1;
        #20;
        reset = 1'b0;
        check_eq("rst_cmd", 32'(bus.motion_cmd), 32'h7);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        check_eq("rst_error", 32'(bus.error), 32'h0);
        check_eq("rst_count", 32'(bus.product_count), 32'h0);
        step();
        check_eq("idle_cmd", 32'(bus.motion_cmd), 32'h7);

        // 2. full batch, ack in 2nd PLACE clock; a start mid-batch is ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                check_eq($sformatf("b_cmd_p%0d_i%0d", p, i), 32'(bus.motion_cmd), 32'(cmd_seq[i]));
                check_eq($sformatf("b_busy_p%0d_i%0d", p, i), 32'(bus.busy), 32'h1);
                if (p == 1 && i == 3) bus.start = 1'b1;
                if (i == 7) bus.product_complete = 1'b1;
                step();
                bus.start = 1'b0;
                bus.product_complete = 1'b0;
            end
            check_eq($sformatf("b_count_p%0d", p), 32'(bus.product_count), 32'(p + 1));
        end
        check_eq("b_done", 32'(bus.done), 32'h1);
        check_eq("b_busy_end", 32'(bus.busy), 32'h0);
        check_eq("b_cmd_end", 32'(bus.motion_cmd), 32'h7);
        step();
        step();
        check_eq("b_done_hold", 32'(bus.done), 32'h1);
        check_eq("b_count_hold", 32'(bus.product_count), 32'h3);

        // 3. delayed ack: five WAIT_ACK clocks
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("w_done_clr", 32'(bus.done), 32'h0);
        check_eq("w_count_clr", 32'(bus.product_count), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("w_cmd_i%0d", i), 32'(bus.motion_cmd), 32'(cmd_seq[i]));
            step();
        end
        for (int w = 1; w <= 5; w++) begin
            check_eq($sformatf("w_wait_cmd_%0d", w), 32'(bus.motion_cmd), 32'h7);
            check_eq($sformatf("w_wait_busy_%0d", w), 32'(bus.busy), 32'h1);
            check_eq($sformatf("w_wait_count_%0d", w), 32'(bus.product_count), 32'h0);
            if (w == 5) bus.product_complete = 1'b1;
            step();
            bus.product_complete = 1'b0;
        end
        check_eq("w_count", 32'(bus.product_count), 32'h1);
        check_eq("w_resume_cmd", 32'(bus.motion_cmd), 32'h0);

        // 5. abort in PICK of product 2
        step();
        step();
        check_eq("a_pick_cmd", 32'(bus.motion_cmd), 32'h1);
        bus.abort = 1'b1;
        step();
        check_eq("a_cmd", 32'(bus.motion_cmd), 32'h7);
        check_eq("a_busy", 32'(bus.busy), 32'h0);
        check_eq("a_count", 32'(bus.product_count), 32'h1);
        check_eq("a_done", 32'(bus.done), 32'h0);
        step();
        check_eq("a_idle_abort_cmd", 32'(bus.motion_cmd), 32'h7);
        check_eq("a_idle_abort_count", 32'(bus.product_count), 32'h1);
        // start wins in IDLE even with abort high
        bus.start = 1'b1;
        step();
        check_eq("sa_idle_cmd", 32'(bus.motion_cmd), 32'h0);
        check_eq("sa_idle_count", 32'(bus.product_count), 32'h0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step();
        // abort wins mid-batch
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("sa_busy_cmd", 32'(bus.motion_cmd), 32'h7);
        check_eq("sa_busy_busy", 32'(bus.busy), 32'h0);

        // 4. never ack: exactly eight WAIT_ACK clocks then ERROR
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int w = 1; w <= 8; w++) begin
            check_eq($sformatf("t_wait_cmd_%0d", w), 32'(bus.motion_cmd), 32'h7);
            check_eq($sformatf("t_wait_busy_%0d", w), 32'(bus.busy), 32'h1);
            check_eq($sformatf("t_wait_err_%0d", w), 32'(bus.error), 32'h0);
            step();
        end
        check_eq("t_error", 32'(bus.error), 32'h1);
        check_eq("t_busy", 32'(bus.busy), 32'h0);
        check_eq("t_count", 32'(bus.product_count), 32'h0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_eq("t_abort_in_error", 32'(bus.error), 32'h1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("t_restart_err", 32'(bus.error), 32'h0);
        check_eq("t_restart_cmd", 32'(bus.motion_cmd), 32'h0);

        // 6. ack held four clocks across PLACE counts once
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("h_cmd_i%0d", i), 32'(bus.motion_cmd), 32'(cmd_seq[i]));
            if (i >= 5) bus.product_complete = 1'b1;
            step();
        end
        check_eq("h_count_a", 32'(bus.product_count), 32'h1);
        check_eq("h_cmd_mp", 32'(bus.motion_cmd), 32'h0);
        step();
        bus.product_complete = 1'b0;
        check_eq("h_count_b", 32'(bus.product_count), 32'h1);
        step();
        step();
        step();
        check_eq("h_move_place", 32'(bus.motion_cmd), 32'h2);

        // async reset mid-MOVE_PLACE, observed before the next edge
        #3;
        reset = 1'b1;
        #1;
        check_eq("ar_cmd", 32'(bus.motion_cmd), 32'h7);
        check_eq("ar_busy", 32'(bus.busy), 32'h0);
        check_eq("ar_count", 32'(bus.product_count), 32'h0);
        check_eq("ar_done", 32'(bus.done), 32'h0);
        check_eq("ar_error", 32'(bus.error), 32'h0);
        #10;
        reset = 1'b0;
        step();
        check_eq("ar_idle_cmd", 32'(bus.motion_cmd), 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
